// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/MEM memory-port arbiter: FSM states, grant owner,
// and the round-robin tie-break rule.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_IF   = 2'd1,
    ARB_MEM  = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_IF  = 1'b0,
    GNT_MEM = 1'b1
  } grant_e;

  // MEM wins a tie unless it also won the previous grant.
  function automatic logic mem_wins(input logic if_want, input logic mem_want,
                                    input grant_e last);
    return mem_want && (!if_want || last == GNT_IF);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// Saturating wait counter for an outstanding bus transaction; flags the cycle
// in which the TIMEOUT_CYCLES-th wait cycle is being spent.
module mem_arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST  = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst || clear)                cnt <= '0;
    else if (enable && cnt != LIMIT) cnt <= cnt + 1'b1;
  end

  assign expired = (TIMEOUT_CYCLES != 0) && enable && (cnt == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (read-only) and the MEM
// stage; one grant at a time, held until the memory reports completion.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_busy_o,
  output logic              if_done_o,
  output logic [DATA_W-1:0] if_data_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  input  logic [3:0]        mem_wmask_i,
  output logic              mem_busy_o,
  output logic              mem_done_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              err_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  output logic [3:0]        bus_wmask_o,
  input  logic [DATA_W-1:0] bus_rdata_i,
  input  logic              bus_done_i
);

  arb_state_e        state, state_nxt;
  grant_e            last_grant, last_grant_nxt;
  logic              if_done_nxt, mem_done_nxt, err_nxt, bus_req_nxt, bus_we_nxt;
  logic [DATA_W-1:0] if_data_nxt, mem_data_nxt, bus_wdata_nxt;
  logic [ADDR_W-1:0] bus_addr_nxt;
  logic [3:0]        bus_wmask_nxt;
  logic              grant, expired, if_want, mem_want;

  // A requester still holds req during its own done cycle; don't regrant it.
  assign if_want  = if_req_i  & ~if_done_o;
  assign mem_want = mem_req_i & ~mem_done_o;

  assign if_busy_o  = (state != ARB_IDLE);
  assign mem_busy_o = (state != ARB_IDLE);

  mem_arb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (grant),
    .enable  (state != ARB_IDLE),
    .expired (expired)
  );

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    if_done_nxt    = 1'b0;
    mem_done_nxt   = 1'b0;
    err_nxt        = 1'b0;
    if_data_nxt    = if_data_o;
    mem_data_nxt   = mem_data_o;
    bus_req_nxt    = bus_req_o;
    bus_we_nxt     = bus_we_o;
    bus_addr_nxt   = bus_addr_o;
    bus_wdata_nxt  = bus_wdata_o;
    bus_wmask_nxt  = bus_wmask_o;
    grant          = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (if_want || mem_want) begin
          grant       = 1'b1;
          bus_req_nxt = 1'b1;
          if (mem_wins(if_want, mem_want, last_grant)) begin
            state_nxt      = ARB_MEM;
            last_grant_nxt = GNT_MEM;
            bus_we_nxt     = mem_we_i;
            bus_addr_nxt   = mem_addr_i;
            bus_wdata_nxt  = mem_wdata_i;
            bus_wmask_nxt  = mem_wmask_i;
          end else begin
            state_nxt      = ARB_IF;
            last_grant_nxt = GNT_IF;
            bus_we_nxt     = 1'b0;
            bus_addr_nxt   = if_addr_i;
            bus_wdata_nxt  = '0;
            bus_wmask_nxt  = 4'b0000;
          end
        end
      end
      ARB_IF, ARB_MEM: begin
        // A real completion wins over a watchdog expiry in the same cycle.
        if (bus_done_i || expired) begin
          state_nxt   = ARB_IDLE;
          bus_req_nxt = 1'b0;
          err_nxt     = ~bus_done_i;
          if (state == ARB_IF) begin
            if_done_nxt = 1'b1;
            if (bus_done_i) if_data_nxt = bus_rdata_i;
          end else begin
            mem_done_nxt = 1'b1;
            if (bus_done_i && !bus_we_o) mem_data_nxt = bus_rdata_i;
          end
        end
      end
      default: begin
        state_nxt   = ARB_IDLE;
        bus_req_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ARB_IDLE;
      last_grant  <= GNT_IF;
      if_done_o   <= 1'b0;
      mem_done_o  <= 1'b0;
      err_o       <= 1'b0;
      if_data_o   <= '0;
      mem_data_o  <= '0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
      bus_wmask_o <= 4'b0000;
    end else begin
      state       <= state_nxt;
      last_grant  <= last_grant_nxt;
      if_done_o   <= if_done_nxt;
      mem_done_o  <= mem_done_nxt;
      err_o       <= err_nxt;
      if_data_o   <= if_data_nxt;
      mem_data_o  <= mem_data_nxt;
      bus_req_o   <= bus_req_nxt;
      bus_we_o    <= bus_we_nxt;
      bus_addr_o  <= bus_addr_nxt;
      bus_wdata_o <= bus_wdata_nxt;
      bus_wmask_o <= bus_wmask_nxt;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Random IF/MEM requesters plus a variable-latency memory, checked every cycle
// against a transaction-level model of who owns the port and for how long.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;
  localparam int NCYC = 3000;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, mem_req, mem_we, bus_done;
  logic [AW-1:0] if_addr, mem_addr;
  logic [DW-1:0] mem_wdata, bus_rdata;
  logic [3:0]    mem_wmask;
  logic          if_busy, if_done, mem_busy, mem_done, err, bus_req, bus_we;
  logic [DW-1:0] if_data, mem_data, bus_wdata;
  logic [AW-1:0] bus_addr;
  logic [3:0]    bus_wmask;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_busy_o(if_busy),
    .if_done_o(if_done), .if_data_o(if_data),
    .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_addr_i(mem_addr),
    .mem_wdata_i(mem_wdata), .mem_wmask_i(mem_wmask), .mem_busy_o(mem_busy),
    .mem_done_o(mem_done), .mem_data_o(mem_data), .err_o(err),
    .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_addr_o(bus_addr),
    .bus_wdata_o(bus_wdata), .bus_wmask_o(bus_wmask),
    .bus_rdata_i(bus_rdata), .bus_done_i(bus_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  // Reference: owner 0 = nobody, 1 = IF, 2 = MEM; age = wait cycles already spent.
  int            owner, age, last, lat;
  logic          m_if_done, m_mem_done, m_err, m_we;
  logic [DW-1:0] m_if_data, m_mem_data, m_wdata;
  logic [AW-1:0] m_addr;
  logic [3:0]    m_wmask;

  task automatic model_reset();
    owner = 0; age = 0; last = 1;
    m_if_done = 0; m_mem_done = 0; m_err = 0; m_we = 0;
    m_if_data = '0; m_mem_data = '0; m_wdata = '0; m_addr = '0; m_wmask = '0;
  endtask

  task automatic model_step();
    logic wi, wm;
    wi = if_req && !m_if_done;
    wm = mem_req && !m_mem_done;
    m_if_done = 0; m_mem_done = 0; m_err = 0;
    if (!rst) begin
      model_reset();
    end else if (owner == 0) begin
      if (wm && (!wi || last == 1)) begin
        owner = 2; last = 2; age = 0;
        m_we = mem_we; m_addr = mem_addr; m_wdata = mem_wdata; m_wmask = mem_wmask;
      end else if (wi) begin
        owner = 1; last = 1; age = 0;
        m_we = 0; m_addr = if_addr; m_wdata = '0; m_wmask = '0;
      end
    end else if (bus_done || age + 1 == TO) begin
      if (owner == 1) begin
        m_if_done = 1;
        if (bus_done) m_if_data = bus_rdata;
      end else begin
        m_mem_done = 1;
        if (bus_done && !m_we) m_mem_data = bus_rdata;
      end
      m_err = !bus_done;
      owner = 0;
    end else begin
      age++;
    end
  endtask

  task automatic check_all();
    chk("if_busy",   64'(if_busy),   64'(owner != 0));
    chk("mem_busy",  64'(mem_busy),  64'(owner != 0));
    chk("if_done",   64'(if_done),   64'(m_if_done));
    chk("mem_done",  64'(mem_done),  64'(m_mem_done));
    chk("err",       64'(err),       64'(m_err));
    chk("if_data",   64'(if_data),   64'(m_if_data));
    chk("mem_data",  64'(mem_data),  64'(m_mem_data));
    chk("bus_req",   64'(bus_req),   64'(owner != 0));
    if (owner != 0) begin
      chk("bus_we",    64'(bus_we),    64'(m_we));
      chk("bus_addr",  64'(bus_addr),  64'(m_addr));
      chk("bus_wdata", 64'(bus_wdata), 64'(m_wdata));
      chk("bus_wmask", 64'(bus_wmask), 64'(m_wmask));
    end
  endtask

  task automatic drive(input int cyc);
    rst = (cyc > 60 && $urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
    if (if_req && m_if_done) if_req = 0;
    else if (if_req && owner == 1 && $urandom_range(0, 39) == 0) if_req = 0;
    else if (!if_req && $urandom_range(0, 2) == 0) begin
      if_req = 1; if_addr = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
    end
    if (mem_req && m_mem_done) mem_req = 0;
    else if (!mem_req && $urandom_range(0, 2) == 0) begin
      mem_req = 1; mem_we = 1'($urandom_range(0, 1));
      mem_addr = $urandom; mem_wdata = $urandom; mem_wmask = 4'($urandom_range(0, 15));
    end
    if (cyc == 0) begin
      if_req = 1; if_addr = 32'h0000_0010;
      mem_req = 1; mem_we = 1; mem_addr = 32'h100; mem_wdata = 32'hDEAD_BEEF; mem_wmask = 4'hF;
    end
    bus_rdata = $urandom;
    if (owner != 0) begin
      if (age == 0) lat = (cyc < 20) ? 3 : $urandom_range(0, 5);
      bus_done = (age == lat);
    end else begin
      bus_done = ($urandom_range(0, 7) == 0);
    end
  endtask

  initial begin
    rst = 0; if_req = 0; mem_req = 0; mem_we = 0; bus_done = 0;
    if_addr = '0; mem_addr = '0; mem_wdata = '0; mem_wmask = '0; bus_rdata = '0; lat = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all();
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      drive(c);
      @(posedge clk);
      model_step();
      #1 check_all();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
